// File: rtl/axi_dma_wr_framer_pkg.sv
// Shared types for the DMA write framer slice.
//   dma_desc_t     : write descriptor (address, byte length), sized for the widest
//                    configuration downstream blocks use.
//   framer_state_t : framer control states.
package axi_dma_pkg;

   localparam int unsigned DESC_ADDR_MAX = 64;
   localparam int unsigned DESC_LEN_MAX  = 32;

   typedef struct packed {
      logic [DESC_ADDR_MAX-1:0] addr;
      logic [DESC_LEN_MAX-1:0]  len;
   } dma_desc_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DESC,
      DATA
   } framer_state_t;

endpackage

// File: rtl/axi_dma_wr_framer_if.sv
// AXI-stream word channel used for both the raw source and the DMA data stream.
//   tdata/tvalid/tlast : master -> slave
//   tready             : slave -> master
interface axi_dma_wr_framer_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axi_dma_wr_frame_buf.sv
// Frame buffer: DEPTH x DATA_WIDTH register array, one write port, one
// asynchronous read port. Cleared on reset so stale data never reaches the output.
//   clk, rst_n     : clock, synchronous active-low reset
//   we/waddr/wdata : write port
//   raddr/rdata    : read port
module axi_dma_wr_frame_buf #(
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned DEPTH      = 16,
   localparam int unsigned IW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [IW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axi_dma_wr_framer.sv
// DMA write framer: gathers source words into frames of up to FRAME_WORDS words,
// issues one descriptor per frame (ring-buffer address, exact byte length), then
// replays the frame on the DMA data stream. Descriptors in flight are counted
// against status pulses and issue stalls at MAX_OUTSTANDING.
//   clk, rst_n                     : clock, synchronous active-low reset
//   cfg_base_addr, cfg_ring_bytes  : ring setup, sampled on cfg_start
//   cfg_start                      : leaves IDLE and starts framing
//   s_axis (slave)                 : raw source words, tlast ends a short frame
//   desc_addr/len/valid/ready      : write descriptor handshake
//   desc_status_valid              : one pulse per completed descriptor
//   m_axis (master)                : frame replay, tlast on final word
//   busy                           : not idle or descriptors outstanding
//   frame_count                    : descriptors issued since cfg_start
module axi_dma_wr_framer
   import axi_dma_pkg::*;
#(
   parameter int unsigned AXI_DATA_WIDTH  = 32,
   parameter int unsigned AXI_ADDR_WIDTH  = 32,
   parameter int unsigned LEN_WIDTH       = 9,
   parameter int unsigned FRAME_WORDS     = 16,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [AXI_ADDR_WIDTH-1:0] cfg_ring_bytes,
   input  logic                      cfg_start,
   axi_dma_wr_framer_if.slave        s_axis,
   output logic [AXI_ADDR_WIDTH-1:0] desc_addr,
   output logic [LEN_WIDTH-1:0]      desc_len,
   output logic                      desc_valid,
   input  logic                      desc_ready,
   input  logic                      desc_status_valid,
   axi_dma_wr_framer_if.master       m_axis,
   output logic                      busy,
   output logic [15:0]               frame_count
);

   localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
   localparam int unsigned IW    = $clog2(FRAME_WORDS);
   localparam int unsigned CW    = IW + 1;
   localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SLOT  = FRAME_WORDS * BYTES;

   if (FRAME_WORDS * BYTES >= 2 ** LEN_WIDTH) begin : g_len_chk
      $error("axi_dma_wr_framer: frame byte length does not fit LEN_WIDTH");
   end
   if (FRAME_WORDS < 2 || (FRAME_WORDS & (FRAME_WORDS - 1)) != 0) begin : g_fw_chk
      $error("axi_dma_wr_framer: FRAME_WORDS must be a power of 2, >= 2");
   end

   framer_state_t             state;
   logic [IW-1:0]             wcnt, rcnt;
   logic [CW-1:0]             nwords;
   logic [AXI_ADDR_WIDTH-1:0] ptr, base, ring_end, ptr_inc;
   logic [OW-1:0]             outst, outst_nxt;
   logic [15:0]               fcnt;
   logic                      s_rdy, d_vld, m_vld, m_lst;
   logic                      s_fire, d_fire, m_fire, s_last, st_dec, room;

   assign s_fire  = s_rdy & s_axis.tvalid;
   assign d_fire  = d_vld & desc_ready;
   assign m_fire  = m_vld & m_axis.tready;
   assign s_last  = s_axis.tlast || (wcnt == IW'(FRAME_WORDS - 1));
   assign st_dec  = desc_status_valid && (outst != '0);
   assign ptr_inc = ptr + AXI_ADDR_WIDTH'(SLOT);

   always_comb begin
      outst_nxt = outst;
      if (d_fire && !st_dec)      outst_nxt = outst + OW'(1);
      else if (!d_fire && st_dec) outst_nxt = outst - OW'(1);
   end

   // Throttle decision uses the post-update count so a status pulse frees a
   // slot for a descriptor presented on the very next cycle.
   assign room = (outst_nxt < OW'(MAX_OUTSTANDING));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         wcnt     <= '0;
         rcnt     <= '0;
         nwords   <= '0;
         ptr      <= '0;
         base     <= '0;
         ring_end <= '0;
         outst    <= '0;
         fcnt     <= '0;
         s_rdy    <= 1'b0;
         d_vld    <= 1'b0;
         m_vld    <= 1'b0;
         m_lst    <= 1'b0;
      end else begin
         outst <= outst_nxt;
         if (d_fire) fcnt <= fcnt + 16'd1;
         case (state)
            IDLE: if (cfg_start) begin
               base     <= cfg_base_addr;
               ring_end <= cfg_base_addr + cfg_ring_bytes;
               ptr      <= cfg_base_addr;
               fcnt     <= '0;
               wcnt     <= '0;
               s_rdy    <= 1'b1;
               state    <= FILL;
            end
            FILL: if (s_fire) begin
               if (s_last) begin
                  nwords <= CW'(wcnt) + CW'(1);
                  s_rdy  <= 1'b0;
                  d_vld  <= room;
                  state  <= DESC;
               end else begin
                  wcnt <= wcnt + IW'(1);
               end
            end
            DESC: if (d_fire) begin
               d_vld <= 1'b0;
               ptr   <= (ptr_inc == ring_end) ? base : ptr_inc;
               rcnt  <= '0;
               m_vld <= 1'b1;
               m_lst <= (nwords == CW'(1));
               state <= DATA;
            end else begin
               d_vld <= room;
            end
            DATA: if (m_fire) begin
               if (m_lst) begin
                  m_vld <= 1'b0;
                  m_lst <= 1'b0;
                  wcnt  <= '0;
                  s_rdy <= 1'b1;
                  state <= FILL;
               end else begin
                  rcnt  <= rcnt + IW'(1);
                  m_lst <= (CW'(rcnt) + CW'(2) == nwords);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   axi_dma_wr_frame_buf #(
      .DATA_WIDTH (AXI_DATA_WIDTH),
      .DEPTH      (FRAME_WORDS)
   ) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (s_fire),
      .waddr (wcnt),
      .wdata (s_axis.tdata),
      .raddr (rcnt),
      .rdata (m_axis.tdata)
   );

   assign s_axis.tready = s_rdy;
   assign m_axis.tvalid = m_vld;
   assign m_axis.tlast  = m_lst;
   assign desc_valid    = d_vld;
   assign desc_addr     = ptr;
   assign desc_len      = LEN_WIDTH'(nwords) * LEN_WIDTH'(BYTES);
   assign busy          = (state != IDLE) || (outst != '0);
   assign frame_count   = fcnt;

endmodule

// File: tb/tb_axi_dma_wr_framer.sv
// Self-checking bench for axi_dma_wr_framer. Frames are described at the word
// level; the reference model derives descriptors (slot address modulo ring,
// byte length) and the expected output beat stream from that description.
module tb_axi_dma_wr_framer;

   localparam int unsigned DW = 32, AW = 32, LW = 9, FW = 16, MO = 4;
   localparam int unsigned SLOT = FW * (DW / 8);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] cfg_base_addr = '0, cfg_ring_bytes = '0;
   logic          cfg_start = 1'b0;
   logic [AW-1:0] desc_addr;
   logic [LW-1:0] desc_len;
   logic          desc_valid, busy;
   logic          desc_ready = 1'b0, desc_status_valid = 1'b0;
   logic [15:0]   frame_count;

   axi_dma_wr_framer_if #(.DATA_WIDTH(DW)) s_if ();
   axi_dma_wr_framer_if #(.DATA_WIDTH(DW)) m_if ();

   axi_dma_wr_framer #(
      .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW),
      .FRAME_WORDS(FW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_base_addr(cfg_base_addr), .cfg_ring_bytes(cfg_ring_bytes), .cfg_start(cfg_start),
      .s_axis(s_if),
      .desc_addr(desc_addr), .desc_len(desc_len), .desc_valid(desc_valid),
      .desc_ready(desc_ready), .desc_status_valid(desc_status_valid),
      .m_axis(m_if),
      .busy(busy), .frame_count(frame_count)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        ends;
   } src_t;

   src_t        src_q[$];
   logic [31:0] exp_da[$], exp_dl[$], got_da[$], got_dl[$], exp_bd[$], got_bd[$];
   logic        exp_bl[$], got_bl[$];

   int checks = 0, failures = 0;
   int cyc = 0, end_cyc = -100, dv_rise = -1, pend_st = 0, fi = 0;
   int m_mode = 1, d_mode = 1;     // 0 = low, 1 = high, 2 = random
   bit src_pop = 0, gap_en = 0, st_auto = 0;
   logic [AW-1:0] ph_base = '0, ph_ring = '0;

   // previous-cycle values for the hold-while-stalled checks
   logic          pd_v = 0, pd_r = 0, pm_v = 0, pm_r = 0, pm_l = 0;
   logic [AW-1:0] pd_a = '0;
   logic [LW-1:0] pd_l = '0;
   logic [DW-1:0] pm_d = '0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Input driver: runs just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (src_pop) begin
         if (src_q.size() > 0) src_q.delete(0);
         src_pop = 0;
      end
      if (src_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = src_q[0].data;
         s_if.tlast  = src_q[0].last;
      end else begin
         s_if.tvalid = 1'b0;
         s_if.tdata  = '0;
         s_if.tlast  = 1'b0;
      end
      m_if.tready = (m_mode == 2) ? 1'($urandom_range(1)) : (m_mode == 1);
      desc_ready  = (d_mode == 2) ? 1'($urandom_range(1)) : (d_mode == 1);
      if (st_auto) begin
         if (pend_st > 0 && $urandom_range(1) == 1) begin
            desc_status_valid = 1'b1;
            pend_st--;
         end else begin
            desc_status_valid = 1'b0;
         end
      end
   end

   // Monitor: samples on the falling edge, between driver updates and DUT edges.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pd_v = 0; pm_v = 0;
      end else begin
         if (s_if.tvalid && s_if.tready && src_q.size() > 0) begin
            src_pop = 1;
            if (src_q[0].ends) end_cyc = cyc;
         end
         if (desc_valid && !pd_v) dv_rise = cyc;
         if (pd_v && !pd_r) begin
            chk("desc_hold_valid", 64'(desc_valid), 64'(1));
            chk("desc_hold_addr", 64'(desc_addr), 64'(pd_a));
            chk("desc_hold_len", 64'(desc_len), 64'(pd_l));
         end
         if (pm_v && !pm_r) begin
            chk("m_hold_valid", 64'(m_if.tvalid), 64'(1));
            chk("m_hold_data", 64'(m_if.tdata), 64'(pm_d));
            chk("m_hold_last", 64'(m_if.tlast), 64'(pm_l));
         end
         if (desc_valid && desc_ready) begin
            got_da.push_back(32'(desc_addr));
            got_dl.push_back(32'(desc_len));
            if (st_auto) pend_st++;
         end
         if (m_if.tvalid && m_if.tready) begin
            got_bd.push_back(m_if.tdata);
            got_bl.push_back(m_if.tlast);
         end
         pd_v = desc_valid; pd_r = desc_ready; pd_a = desc_addr; pd_l = desc_len;
         pm_v = m_if.tvalid; pm_r = m_if.tready; pm_d = m_if.tdata; pm_l = m_if.tlast;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(int n);
      tick();
      rst_n = 1'b0;
      repeat (n) tick();
      src_q.delete(); src_pop = 0; pend_st = 0; desc_status_valid = 1'b0;
      exp_da.delete(); exp_dl.delete(); exp_bd.delete(); exp_bl.delete();
      got_da.delete(); got_dl.delete(); got_bd.delete(); got_bl.delete();
      rst_n = 1'b1;
   endtask

   task automatic start(logic [AW-1:0] b, logic [AW-1:0] r);
      tick();
      cfg_base_addr = b; cfg_ring_bytes = r; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      ph_base = b; ph_ring = r; fi = 0;
   endtask

   // Reference model: one frame of n words -> source entries, one descriptor,
   // n output beats with tlast on the final one.
   task automatic add_frame(int n, bit rnd, int startv, bit tl_full);
      src_t e;
      for (int i = 0; i < n; i++) begin
         e.data = rnd ? $urandom : 32'(startv + i);
         e.ends = (i == n - 1);
         e.last = e.ends && (n < FW || tl_full);
         src_q.push_back(e);
         exp_bd.push_back(e.data);
         exp_bl.push_back(e.ends);
      end
      exp_da.push_back(32'(ph_base + AW'((fi * SLOT) % int'(ph_ring))));
      exp_dl.push_back(32'(n * (DW / 8)));
      fi++;
   endtask

   task automatic wait_got(int nd, int nb, int budget, string tag);
      int k = 0;
      while ((got_da.size() < nd || got_bd.size() < nb) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(got_da.size() >= nd && got_bd.size() >= nb), 64'(1));
   endtask

   task automatic cmp_descs(int n, string tag);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_desc_addr"}, 64'(got_da[i]), 64'(exp_da[i]));
         chk({tag, "_desc_len"}, 64'(got_dl[i]), 64'(exp_dl[i]));
      end
      for (int i = 0; i < n; i++) begin
         if (got_da.size() > 0) begin got_da.delete(0); got_dl.delete(0); end
         if (exp_da.size() > 0) begin exp_da.delete(0); exp_dl.delete(0); end
      end
   endtask

   task automatic cmp_beats(int n, string tag);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_beat_data"}, 64'(got_bd[i]), 64'(exp_bd[i]));
         chk({tag, "_beat_last"}, 64'(got_bl[i]), 64'(exp_bl[i]));
      end
      for (int i = 0; i < n; i++) begin
         if (got_bd.size() > 0) begin got_bd.delete(0); got_bl.delete(0); end
         if (exp_bd.size() > 0) begin exp_bd.delete(0); exp_bl.delete(0); end
      end
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_s_tready"}, 64'(s_if.tready), 64'(0));
      chk({tag, "_desc_valid"}, 64'(desc_valid), 64'(0));
      chk({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'(0));
      chk({tag, "_m_tlast"}, 64'(m_if.tlast), 64'(0));
      chk({tag, "_m_tdata"}, 64'(m_if.tdata), 64'(0));
      chk({tag, "_desc_addr"}, 64'(desc_addr), 64'(0));
      chk({tag, "_desc_len"}, 64'(desc_len), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_frame_count"}, 64'(frame_count), 64'(0));
   endtask

   initial begin
      int total;
      int n;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;

      // power-on reset
      repeat (3) tick();
      @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // reset in the middle of filling a frame
      start(32'h1000, 32'h100);
      add_frame(8, 0, 100, 0);
      repeat (6) tick();
      do_reset(2);
      @(negedge clk);
      chk("rst_fill_s_tready", 64'(s_if.tready), 64'(0));
      chk("rst_fill_busy", 64'(busy), 64'(0));
      chk("rst_fill_frame_count", 64'(frame_count), 64'(0));

      // first full frame 0..15
      st_auto = 1;
      start(32'h1000, 32'h100);
      @(negedge clk);
      chk("start_busy", 64'(busy), 64'(1));
      chk("start_s_tready", 64'(s_if.tready), 64'(1));
      add_frame(16, 0, 0, 0);
      wait_got(1, 16, 200, "frame1_timeout");
      chk("desc_latency", 64'(dv_rise), 64'(end_cyc + 1));
      cmp_descs(1, "frame1");
      cmp_beats(16, "frame1");

      // four more full frames: address wraps on the fifth
      for (int k = 0; k < 4; k++) add_frame(16, 1, 0, 0);
      wait_got(4, 64, 800, "frames5_timeout");
      cmp_descs(4, "frames5");
      cmp_beats(64, "frames5");
      chk("frame_count_5", 64'(frame_count), 64'(5));

      // short frame, then a full frame in the next slot
      add_frame(3, 1, 0, 0);
      add_frame(16, 1, 0, 1);
      wait_got(2, 19, 400, "short_timeout");
      cmp_descs(2, "short");
      cmp_beats(19, "short");

      // random lengths with back-pressure on every channel
      gap_en = 1; m_mode = 2; d_mode = 2;
      total = 0;
      for (int k = 0; k < 24; k++) begin
         n = int'($urandom_range(1, 16));
         add_frame(n, 1, 0, 1'($urandom_range(1)));
         total += n;
      end
      wait_got(24, total, 8000, "random_timeout");
      cmp_descs(24, "random");
      cmp_beats(total, "random");
      chk("frame_count_random", 64'(frame_count), 64'(16'(fi)));
      gap_en = 0; m_mode = 1; d_mode = 1;

      // throttle: no status returned
      st_auto = 0;
      do_reset(2);
      start(32'h2000, 32'h80);
      for (int k = 0; k < 5; k++) add_frame(16, 1, 0, 0);
      repeat (250) tick();
      @(negedge clk);
      chk("throttle_desc_count", 64'(got_da.size()), 64'(4));
      chk("throttle_desc_valid", 64'(desc_valid), 64'(0));
      chk("throttle_frame_count", 64'(frame_count), 64'(4));
      // one status frees a slot; a second status coincides with the handshake
      tick();
      desc_status_valid = 1'b1;
      tick();
      @(negedge clk);
      chk("unthrottle_desc_valid", 64'(desc_valid), 64'(1));
      tick();
      desc_status_valid = 1'b0;
      add_frame(16, 1, 0, 0);
      add_frame(16, 1, 0, 0);
      repeat (200) tick();
      @(negedge clk);
      chk("same_cycle_desc_count", 64'(got_da.size()), 64'(6));
      chk("same_cycle_desc_valid", 64'(desc_valid), 64'(0));
      chk("same_cycle_frame_count", 64'(frame_count), 64'(6));
      cmp_descs(6, "throttle");
      cmp_beats(96, "throttle");

      // reset with a frame stalled on the data stream
      m_mode = 0;
      tick();
      desc_status_valid = 1'b1;
      tick();
      desc_status_valid = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      chk("stall_m_tvalid", 64'(m_if.tvalid), 64'(1));
      chk("stall_m_tlast", 64'(m_if.tlast), 64'(0));
      chk("stall_desc_count", 64'(got_da.size()), 64'(1));
      do_reset(1);
      @(negedge clk);
      chk_all_zero("rst_data");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
